// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg -- shared definitions for the serial transmitter slice.
//   txState_t       : transmitter FSM state encoding
//   ST_*            : bit positions inside the 16-bit status word
//   DEFAULT_CLK_DIV : clk cycles per serial bit (25 MHz / 115200 baud)
//   statusWord()    : packs the status flags into the CPU read word
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  localparam int DEFAULT_CLK_DIV = 217;

  localparam int ST_BUSY     = 0;
  localparam int ST_EMPTY    = 1;
  localparam int ST_FULL     = 2;
  localparam int ST_OVERFLOW = 3;

  function automatic logic [15:0] statusWord(input logic overflow, input logic full,
                                             input logic empty, input logic busy);
    logic [15:0] w;
    w = 16'h0000;
    w[ST_OVERFLOW] = overflow;
    w[ST_FULL]     = full;
    w[ST_EMPTY]    = empty;
    w[ST_BUSY]     = busy;
    return w;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if -- CPU register bus of the serial transmitter.
//   wrEn   : write strobe, one-cycle qualified
//   rdEn   : read strobe, one-cycle qualified
//   addr   : register select, 0 = data, 1 = status
//   wrData : write data, only [7:0] carries the byte
//   rdData : registered read data, valid the cycle after rdEn
// Strobe semantics: there is no ready/stall; every cycle with wrEn or rdEn
// high is one complete access, and the slave never back-pressures.
interface serial_tx_if;
  import serial_tx_pkg::*;

  logic        wrEn;
  logic        rdEn;
  logic        addr;
  logic [15:0] wrData;
  logic [15:0] rdData;

  modport master (output wrEn, output rdEn, output addr, output wrData, input rdData);
  modport slave  (input wrEn, input rdEn, input addr, input wrData, output rdData);

endinterface

// File: rtl/serial_tx_fifo.sv
// tx_fifo -- parameterised synchronous FIFO with look-ahead head output.
//   clk, rst : clock, asynchronous active-high reset (pointers only)
//   push     : write wdata when not full, or when full with a pop this cycle
//   pop      : discard the head when not empty
//   wdata    : data to write
//   rdata    : current head entry (combinational from storage)
//   full     : DEPTH entries held
//   empty    : no entries held
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full (MSBs differ) from empty.
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  assign doPop  = pop && !empty;
  // When full, the slot being written is the head being popped; the head is
  // read combinationally before the edge, so the overwrite is safe.
  assign doPush = push && (!full || doPop);
  assign rdata  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx -- CPU-mapped 8N1 serial transmitter with a transmit FIFO.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : register bus; addr 0 = data (write pushes a byte,
//                     read returns 0), addr 1 = status
//                     {12'b0, overflow, full, empty, busy}
//   txd             : registered serial line, idle high
//   interruptSignal : one-cycle pulse when the last queued frame finishes
//   interruptIndex  : constant IRQ_INDEX
//   dbgState        : current FSM state
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int          CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int          DEPTH     = 4,
  parameter logic [3:0]  IRQ_INDEX = 4'd5
) (
  input  logic        clk,
  input  logic        rst,
  serial_tx_if.slave  bus,
  output logic        txd,
  output logic        interruptSignal,
  output logic [3:0]  interruptIndex,
  output txState_t    dbgState
);

  localparam int           CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  txState_t      state;
  logic [CW-1:0] baudCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          overflow;

  logic          fifoFull;
  logic          fifoEmpty;
  logic [7:0]    fifoHead;
  logic          baudDone;
  logic          pop;
  logic          dataWr;
  logic          push;
  logic          drop;
  logic          statusRd;
  logic          busy;
  logic          unusedWrHi;

  assign baudDone   = (baudCnt == '0);
  // Pops happen only when a new frame is launched: from IDLE, or back to
  // back at the last STOP cycle.
  assign pop        = !fifoEmpty && ((state == IDLE) || ((state == STOP) && baudDone));
  assign dataWr     = bus.wrEn && !bus.addr;
  assign push       = dataWr && (!fifoFull || pop);
  assign drop       = dataWr && fifoFull && !pop;
  assign statusRd   = bus.rdEn && bus.addr;
  assign busy       = (state != IDLE);
  assign unusedWrHi = ^bus.wrData[15:8];

  assign interruptIndex = IRQ_INDEX;
  assign dbgState       = state;

  tx_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.wrData[7:0]),
    .rdata (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      baudCnt         <= '0;
      bitCnt          <= '0;
      shiftReg        <= '0;
      txd             <= 1'b1;
      interruptSignal <= 1'b0;
    end else begin
      interruptSignal <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            shiftReg <= fifoHead;
            baudCnt  <= RELOAD;
            txd      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baudDone) begin
            baudCnt <= RELOAD;
            bitCnt  <= '0;
            txd     <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        DATA: begin
          if (baudDone) begin
            baudCnt <= RELOAD;
            if (bitCnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              // txd takes the next bit before the shift lands.
              bitCnt   <= bitCnt + 1'b1;
              shiftReg <= {1'b0, shiftReg[7:1]};
              txd      <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        STOP: begin
          if (baudDone) begin
            if (!fifoEmpty) begin
              shiftReg <= fifoHead;
              baudCnt  <= RELOAD;
              txd      <= 1'b0;
              state    <= START;
            end else begin
              interruptSignal <= 1'b1;
              state           <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      bus.rdData <= 16'h0000;
    end else begin
      // A drop in the same cycle as a status read wins over the clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (statusRd) begin
        overflow <= 1'b0;
      end
      if (bus.rdEn) begin
        bus.rdData <= bus.addr ? statusWord(overflow, fifoFull, fifoEmpty, busy) : 16'h0000;
      end
    end
  end

endmodule
